alu_share_arbiter: RTL

Sequencer and two-port arbiter for the single shared ALU. It accepts operation requests from two requesters, each carrying a 7-bit selector `{funct7, ALU_Op, funct3}` and two operands. It grants one request at a time with round-robin fairness and decodes the selector into the 4-bit ALU operation code. It drives the ALU from registered operands, captures the result, and returns it to the winner with a one-cycle done pulse. It sits between the requesters (core execute path, address/debug path) and the combinational ALU.

---
 rtl/alu_share_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Two-port round-robin arbiter and sequencer for the single shared ALU.
//   Winner's operands and decoded op are registered toward the ALU; the
//   result is captured one cycle later and returned with a one-cycle done.
//   Fixed 3-cycle turnaround: IDLE -> ISSUE -> DONE -> IDLE.
// Ports
//   clk, reset            clock, async active-low reset
//   req*_i/sel*_i/a*_i/b*_i  requester 0/1 request, {f7,op[2:0],f3[2:0]}, operands
//   done*_o               one-cycle result-valid pulse for requester 0/1
//   result_o, zero_o      captured ALU result / zero flag
//   unsup_o               selector was not a supported encoding (with done)
//   busy_o                high in ISSUE and DONE
//   alu_a_o/alu_b_o/alu_op_o  registered ALU inputs
//   alu_result_i/alu_zero_i   combinational ALU outputs
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic [6:0]            sel0_i,
    input  logic [6:0]            sel1_i,
    input  logic [DATA_WIDTH-1:0] a0_i,
    input  logic [DATA_WIDTH-1:0] b0_i,
    input  logic [DATA_WIDTH-1:0] a1_i,
    input  logic [DATA_WIDTH-1:0] b1_i,
    output logic                  done0_o,
    output logic                  done1_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  unsup_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [3:0]            alu_op_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  alu_zero_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_gnt;     // requester currently being served
    logic                  r_last;    // requester served most recently
    logic                  r_unsup;
    logic [DATA_WIDTH-1:0] r_alu_a, r_alu_b, r_result;
    logic [3:0]            r_alu_op;
    logic                  r_zero;

    logic                  w_gnt_vld, w_gnt_id;
    logic [6:0]            w_sel;
    logic [3:0]            w_op;
    logic                  w_unsup;

    // Selector {f7, op[2:0], f3[2:0]} -> {unsupported, ALU code}
    function automatic logic [4:0] decode(input logic [6:0] sel);
        casez (sel)
            7'b0_000_000: decode = 5'b0_0000;  // ADD
            7'b1_000_000: decode = 5'b0_0001;  // SUB
            7'b?_001_000: decode = 5'b0_0000;  // ADDI
            7'b?_001_110: decode = 5'b0_0011;  // ORI
            7'b?_111_???: decode = 5'b0_0010;  // LUI
            default:      decode = 5'b1_0000;
        endcase
    endfunction

    // On a tie the requester not served last wins
    always_comb begin
        w_gnt_vld = req0_i | req1_i;
        w_gnt_id  = (req0_i & req1_i) ? ~r_last : req1_i;
        w_sel     = w_gnt_id ? sel1_i : sel0_i;
        {w_unsup, w_op} = decode(w_sel);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers; operands are only sampled on the grant edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
            r_unsup  <= 1'b0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_gnt_vld) begin
                    r_gnt    <= w_gnt_id;
                    r_unsup  <= w_unsup;
                    r_alu_a  <= w_gnt_id ? a1_i : a0_i;
                    r_alu_b  <= w_gnt_id ? b1_i : b0_i;
                    r_alu_op <= w_op;
                end
                S_ISSUE: begin
                    r_result <= alu_result_i;
                    r_zero   <= alu_zero_i;
                end
                S_DONE:  r_last <= r_gnt;
                default: ;
            endcase
        end
    end

    // Outputs: decoded from flops only
    always_comb begin
        busy_o   = (r_state != S_IDLE);
        done0_o  = (r_state == S_DONE) & ~r_gnt;
        done1_o  = (r_state == S_DONE) &  r_gnt;
        unsup_o  = (r_state == S_DONE) &  r_unsup;
        result_o = r_result;
        zero_o   = r_zero;
        alu_a_o  = r_alu_a;
        alu_b_o  = r_alu_b;
        alu_op_o = r_alu_op;
    end

endmodule
